// File: rtl/bsg_set_bit_iter_pkg.sv
// Shared types for the set-bit iterator.
//   state_e : iterator control state (IDLE waits for a mask, BUSY issues indices)
// Optional feature macro used by the iterator: BSG_SET_BIT_ITER_ABORT_EN.
package bsg_set_bit_iter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_counting_leading_zeros.sv
// Purpose: count leading zeros of a width_p-bit vector (all-zero input yields width_p).
// Latency: purely combinational.
// Backpressure: none, no handshake.
// Ports:
//   a_i    in  width_p           vector to scan
//   clz_o  out $clog2(width_p)+1 number of zeros above the highest set bit
module bsg_counting_leading_zeros #(
  parameter int width_p = 32,
  localparam int lg_width_lp = $clog2(width_p)
) (
  input  logic [width_p-1:0]   a_i,
  output logic [lg_width_lp:0] clz_o
);

  // Scan upward so the highest set bit is the last one to write the result.
  always_comb begin
    clz_o = (lg_width_lp+1)'(width_p);
    for (int i = 0; i < width_p; i++) begin
      if (a_i[i]) begin
        clz_o = (lg_width_lp+1)'(width_p - 1 - i);
      end
    end
  end

endmodule

// File: rtl/bsg_set_bit_iterator.sv
// Purpose: latch a request mask and issue the index of each set bit, highest priority first.
// Latency: first idx_o valid one cycle after the mask is loaded; one index per yumi_i.
// Backpressure: idx_o/last_o held until yumi_i; new mask accepted only when idle or on the final consume.
// Ports:
//   clk_i, reset_i        clock and synchronous active-high reset
//   v_i, mask_i, ready_o  mask load handshake (load = v_i & ready_o); zero masks are dropped
//   v_o, idx_o, last_o    current set-bit index, last_o marks the final bit of the mask
//   yumi_i                consumer takes idx_o (only legal while v_o=1)
//   abort_i               present only with BSG_SET_BIT_ITER_ABORT_EN: drop remaining bits
module bsg_set_bit_iterator
  import bsg_set_bit_iter_pkg::*;
#(
  parameter int width_p     = 32,
  parameter bit msb_first_p = 1'b1,
  localparam int lg_width_lp = $clog2(width_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     mask_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [lg_width_lp-1:0] idx_o,
  output logic                   last_o,
  input  logic                   yumi_i
`ifdef BSG_SET_BIT_ITER_ABORT_EN
  ,
  input  logic                   abort_i
`endif
);

  localparam logic [lg_width_lp:0] max_idx_lp = (lg_width_lp+1)'(width_p - 1);

  state_e               state_r;
  logic [width_p-1:0]   mask_r;
  logic [width_p-1:0]   clz_in;
  logic [lg_width_lp:0] clz;
  logic [lg_width_lp:0] idx_full;
  logic [lg_width_lp-1:0] idx;
  logic [width_p-1:0]   clear_mask;
  logic                 busy;
  logic                 single_bit;
  logic                 load;
  logic                 consume;
  logic                 abort;

  // LSB-first order is the leading-zero count of the bit-reversed mask.
  always_comb begin
    clz_in = '0;
    for (int i = 0; i < width_p; i++) begin
      clz_in[i] = msb_first_p ? mask_r[i] : mask_r[width_p-1-i];
    end
  end

  bsg_counting_leading_zeros #(.width_p(width_p)) clz_u (
    .a_i   (clz_in),
    .clz_o (clz)
  );

  assign idx_full   = msb_first_p ? (max_idx_lp - clz) : clz;
  assign idx        = idx_full[lg_width_lp-1:0];
  assign clear_mask = width_p'(1) << idx;
  assign single_bit = ((mask_r & (mask_r - width_p'(1))) == '0);

  assign busy    = (state_r == BUSY);
  assign v_o     = busy & ~reset_i;
  assign idx_o   = v_o ? idx : '0;
  assign last_o  = v_o & single_bit;
  // Final consume frees the slot in the same cycle so masks can stream back to back.
  assign ready_o = ~reset_i & (~busy | (v_o & last_o & yumi_i));

  assign load    = v_i & ready_o;
  assign consume = v_o & yumi_i;

`ifdef BSG_SET_BIT_ITER_ABORT_EN
  assign abort = busy & abort_i;
`else
  assign abort = 1'b0;
`endif

  // A nonzero load wins (it can only coincide with the final consume); abort
  // beats a plain consume. A zero mask is dropped: the consume branch or the
  // hold path already leaves the block idle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      mask_r  <= '0;
    end else if (load && (mask_i != '0)) begin
      state_r <= BUSY;
      mask_r  <= mask_i;
    end else if (abort) begin
      state_r <= IDLE;
      mask_r  <= '0;
    end else if (consume) begin
      mask_r <= mask_r & ~clear_mask;
      if (single_bit) begin
        state_r <= IDLE;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("bsg_set_bit_iterator: yumi_i asserted while v_o=0");
    end
  end
`endif

endmodule
